sequence_presenter: RTL and testbench

- Upstream stage of the sequence checker.
- On game start, generates a random 5-symbol sequence and writes it as one 20-bit word to RAM address 0. It then plays the first LVL symbols to the player display and pulses display_done.
- Consumes the checker's correct/incorrect pulses to advance the level, declare a win, or declare a loss.
- Owns the LVL register that the checker reads.

---
 rtl/sequence_presenter_pkg.sv | 32 +++
 rtl/sequence_presenter_if.sv | 36 +++
 rtl/sequence_presenter_lfsr.sv | 28 ++
 rtl/sequence_presenter.sv | 173 +++++++++++++++++
 tb/tb_sequence_presenter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sequence_presenter_pkg.sv
// Shared game definitions for the sequence presenter and the sequence checker.
// Holds the presenter state encoding, game-size constants, the LVL width that
// both blocks agree on, and a helper that extracts one displayed symbol.
package sequence_presenter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GEN,
    ST_WRITE,
    ST_GAP,
    ST_SHOW,
    ST_DONE,
    ST_WAIT,
    ST_WIN,
    ST_LOSE
  } state_t;

  localparam int MAX_LVL = 5;
  localparam int NUM_SYM = 5;
  localparam int SEQ_W   = 20;
  localparam int ADDR_W  = 5;
  localparam logic [ADDR_W-1:0] SEQ_ADDR = 5'd0;
  localparam int LVL_W   = 3;
  localparam int IDX_W   = 3;

  // Symbol 0 lives in the top nibble, symbol 4 in the bottom nibble.
  function automatic logic [3:0] seq_nibble(input logic [SEQ_W-1:0] seq,
                                            input logic [IDX_W-1:0] idx);
    return seq[(SEQ_W - 4) - 4 * int'(idx) +: 4];
  endfunction

endpackage

// File: rtl/sequence_presenter_if.sv
// Bus bundle between the sequence presenter and its environment.
//   start/correct/incorrect : one-cycle control pulses into the presenter
//   RAM_w/RAM_addr/RAM_wdata: single-word sequence write toward the RAM
//   LVL                     : current level, read by the checker
//   display_done/digit_out/digit_valid : player display playback
//   win/lose                : held game result
// master = presenter side, slave = environment side.
interface sequence_presenter_if;
  import sequence_presenter_pkg::*;

  logic              start;
  logic              correct;
  logic              incorrect;
  logic              RAM_w;
  logic [ADDR_W-1:0] RAM_addr;
  logic [SEQ_W-1:0]  RAM_wdata;
  logic [LVL_W-1:0]  LVL;
  logic              display_done;
  logic [3:0]        digit_out;
  logic              digit_valid;
  logic              win;
  logic              lose;

  modport master (
    input  start, correct, incorrect,
    output RAM_w, RAM_addr, RAM_wdata, LVL, display_done,
           digit_out, digit_valid, win, lose
  );

  modport slave (
    output start, correct, incorrect,
    input  RAM_w, RAM_addr, RAM_wdata, LVL, display_done,
           digit_out, digit_valid, win, lose
  );

endinterface

// File: rtl/sequence_presenter_lfsr.sv
// Free-running 20-bit Fibonacci LFSR (taps 20,17) used as the symbol source.
//   clk     : system clock
//   rst     : asynchronous active-low reset, loads SEED
//   i_en    : advance enable
//   o_bits  : low OUT_W bits of the current LFSR state
module sequence_presenter_lfsr #(
  parameter logic [19:0] SEED  = 20'hACE1,
  parameter int          OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_bits
);

  logic [19:0] r_lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[18:0], r_lfsr[19] ^ r_lfsr[16]};
    end
  end

  assign o_bits = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/sequence_presenter.sv
// Sequence presenter: on start, builds a random 5-symbol sequence, writes it
// as one word to RAM address 0, plays the first LVL symbols on the display,
// then reacts to the checker's correct/incorrect pulses (next level, win, lose).
//   clk, rst (async active-low)
//   bus (master): start/correct/incorrect in; RAM write, LVL, display and
//                 win/lose out, all registered.
module sequence_presenter
  import sequence_presenter_pkg::*;
#(
  parameter int          ON_TICKS  = 25000000,
  parameter int          OFF_TICKS = 12500000,
  parameter int          SYM_BITS  = 2,
  parameter logic [19:0] LFSR_SEED = 20'hACE1
) (
  input logic                  clk,
  input logic                  rst,
  sequence_presenter_if.master bus
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TICK_W    = $clog2(MAX_TICKS + 1);
  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_TICKS - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_TICKS - 1);

  state_t             r_state;
  logic [SEQ_W-1:0]   r_seq;
  logic [TICK_W-1:0]  r_tick;
  logic [IDX_W-1:0]   r_idx;
  logic [LVL_W-1:0]   r_lvl;
  logic               r_ram_w;
  logic [SEQ_W-1:0]   r_wdata;
  logic [3:0]         r_digit;
  logic               r_dvalid;
  logic               r_done;
  logic               r_win;
  logic               r_lose;

  logic [SYM_BITS-1:0] w_rand;
  logic [3:0]          w_sym;
  logic [SEQ_W-1:0]    w_seq_shift;
  logic                w_lfsr_en;

  // Runs in every state so the generated sequence depends on start timing.
  assign w_lfsr_en = 1'b1;

  sequence_presenter_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (SYM_BITS)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_lfsr_en),
    .o_bits (w_rand)
  );

  always_comb begin
    w_sym                 = '0;
    w_sym[SYM_BITS-1:0]   = w_rand;
  end

  // New symbols enter at the LSB so the first generated one ends up on top.
  assign w_seq_shift = {r_seq[SEQ_W-5:0], w_sym};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_seq    <= '0;
      r_tick   <= '0;
      r_idx    <= '0;
      r_lvl    <= LVL_W'(1);
      r_ram_w  <= 1'b0;
      r_wdata  <= '0;
      r_digit  <= '0;
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
    end else begin
      // Pulse outputs and the tick counter fall back to zero unless a
      // state below keeps them; this also clears the tick on every entry.
      r_ram_w <= 1'b0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_tick  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_GEN;
            r_idx   <= '0;
          end
        end
        ST_GEN: begin
          r_seq <= w_seq_shift;
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NUM_SYM - 1)) begin
            r_state <= ST_WRITE;
            r_ram_w <= 1'b1;
            r_wdata <= w_seq_shift;
          end
        end
        ST_WRITE: begin
          r_win   <= 1'b0;
          r_lose  <= 1'b0;
          r_lvl   <= LVL_W'(1);
          r_idx   <= '0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_tick == OFF_LAST) begin
            if (r_idx < r_lvl) begin
              r_state  <= ST_SHOW;
              r_digit  <= seq_nibble(r_seq, r_idx);
              r_dvalid <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        ST_SHOW: begin
          if (r_tick == ON_LAST) begin
            r_idx    <= r_idx + IDX_W'(1);
            r_state  <= ST_GAP;
            r_digit  <= '0;
            r_dvalid <= 1'b0;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // incorrect has priority over a simultaneous correct
          if (bus.incorrect) begin
            r_state <= ST_LOSE;
            r_lose  <= 1'b1;
            r_lvl   <= LVL_W'(1);
          end else if (bus.correct) begin
            if (r_lvl == LVL_W'(MAX_LVL)) begin
              r_state <= ST_WIN;
              r_win   <= 1'b1;
            end else begin
              r_lvl   <= r_lvl + LVL_W'(1);
              r_idx   <= '0;
              r_state <= ST_GAP;
            end
          end
        end
        ST_WIN, ST_LOSE: begin
          if (bus.start) begin
            r_state <= ST_GEN;
            r_idx   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.RAM_w        = r_ram_w;
  assign bus.RAM_addr     = SEQ_ADDR;
  assign bus.RAM_wdata    = r_wdata;
  assign bus.LVL          = r_lvl;
  assign bus.display_done = r_done;
  assign bus.digit_out    = r_digit;
  assign bus.digit_valid  = r_dvalid;
  assign bus.win          = r_win;
  assign bus.lose         = r_lose;

endmodule

// File: tb/tb_sequence_presenter.sv
`timescale 1ns/1ps
module tb_sequence_presenter;
  import sequence_presenter_pkg::*;

  localparam int ON   = 4;
  localparam int OFF  = 2;
  localparam int SYMB = 2;
  localparam int PER  = ON + OFF;
  localparam logic [19:0] SEED = 20'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sequence_presenter_if bus();

  sequence_presenter #(
    .ON_TICKS  (ON),
    .OFF_TICKS (OFF),
    .SYM_BITS  (SYMB),
    .LFSR_SEED (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [19:0] cur_w;

  // Number of clock edges since reset was last released.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    int         act;   // 0 correct, 1 incorrect, 2 both
    logic [2:0] lvl;
    logic       win;
    logic       lose;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic c, input logic i);
    bus.start     = s;
    bus.correct   = c;
    bus.incorrect = i;
  endtask

  // LFSR value after n edges: Fibonacci, taps 20 and 17.
  function automatic logic [19:0] lfsr_at(input int n);
    logic [19:0] x = SEED;
    for (int k = 0; k < n; k++) x = {x[18:0], x[19] ^ x[16]};
    return x;
  endfunction

  // Start sampled in the cycle whose edge count is ct: GEN cycles are ct+1..ct+5.
  function automatic logic [19:0] exp_word(input int ct);
    logic [19:0] w = '0;
    logic [19:0] x;
    for (int k = 1; k <= NUM_SYM; k++) begin
      x = lfsr_at(ct + k);
      w = {w[15:0], 4'(x[SYMB-1:0])};
    end
    return w;
  endfunction

  function automatic logic nibbles_ok(input logic [19:0] w);
    for (int k = 0; k < 5; k++)
      if (w[4*k +: 4] > 4'((1 << SYMB) - 1)) return 1'b0;
    return 1'b1;
  endfunction

  // Checks the display trace for a playback triggered in the current cycle.
  task automatic play(input int lvl, input bit noise);
    int total = lvl * PER + OFF + 1;
    int p;
    int fn = -1;
    int first_done = -1;
    logic [3:0] ed;
    logic ev, edn;
    logic [3:0] fd;
    logic fv, fdn, fe_v, fe_dn;
    logic [3:0] fe_d;
    for (int n = 1; n <= total; n++) begin
      step();
      p   = n - 1;
      ev  = 1'b0;
      ed  = 4'd0;
      edn = (n == total);
      if (p < lvl * PER && (p % PER) >= OFF) begin
        ev = 1'b1;
        ed = cur_w[19 - 4 * (p / PER) -: 4];
      end
      if (bus.display_done === 1'b1 && first_done < 0) first_done = n;
      if (fn < 0 && (bus.digit_valid !== ev || bus.digit_out !== ed ||
                     bus.display_done !== edn || bus.RAM_w !== 1'b0)) begin
        fn = n; fv = bus.digit_valid; fd = bus.digit_out; fdn = bus.display_done;
        fe_v = ev; fe_d = ed; fe_dn = edn;
      end
      if (noise && n < total)
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
      else
        drive(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (fn >= 0) begin
      errors++;
      $display("FAIL playback_L%0d: cycle %0d got valid=%b digit=%0d done=%b expected valid=%b digit=%0d done=%b",
               lvl, fn, fv, fd, fdn, fe_v, fe_d, fe_dn);
    end
    chk("done_latency", first_done, total);
    chk("lvl_after_play", bus.LVL, lvl);
    chk("win_low_in_play", bus.win, 1'b0);
    chk("lose_low_in_play", bus.lose, 1'b0);
  endtask

  task automatic new_game();
    int d = $urandom_range(0, 15);
    int ct;
    int n;
    repeat (d) step();
    drive(1'b1, 1'b0, 1'b0);
    ct    = cyc;
    cur_w = exp_word(ct);
    step();
    drive(1'b0, 1'b0, 1'b0);
    n = 1;
    while (n < 12 && bus.RAM_w !== 1'b1) begin
      step();
      n++;
    end
    chk("ram_w_latency", n, 6);
    chk("ram_addr", bus.RAM_addr, 0);
    chk("ram_wdata", bus.RAM_wdata, cur_w);
    chk("nibble_range", nibbles_ok(bus.RAM_wdata), 1'b1);
    play(1, 1'b1);
  endtask

  // From the cycle after display_done: idle some WAIT cycles, then drive the action.
  task automatic wait_act(input int act);
    int d = $urandom_range(0, 6);
    int bad = 0;
    step();
    for (int k = 0; k < d; k++) begin
      if (bus.digit_valid !== 1'b0 || bus.display_done !== 1'b0) bad++;
      step();
    end
    chk("wait_idle", bad, 0);
    drive(1'b0, act != 1, act != 0);
  endtask

  task automatic terminal_hold(input logic ew, input logic el, input logic [2:0] elvl);
    int bad = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, k == 2 || k == 5, k == 4);
      step();
      if (bus.win !== ew || bus.lose !== el || bus.LVL !== elvl ||
          bus.digit_valid !== 1'b0 || bus.display_done !== 1'b0 || bus.RAM_w !== 1'b0) bad++;
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("terminal_hold", bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bad;
    tbl[0] = '{0, 3'd2, 1'b0, 1'b0};
    tbl[1] = '{0, 3'd3, 1'b0, 1'b0};
    tbl[2] = '{0, 3'd4, 1'b0, 1'b0};
    tbl[3] = '{0, 3'd5, 1'b0, 1'b0};
    tbl[4] = '{0, 3'd5, 1'b1, 1'b0};
    tbl[5] = '{0, 3'd2, 1'b0, 1'b0};
    tbl[6] = '{0, 3'd3, 1'b0, 1'b0};
    tbl[7] = '{2, 3'd1, 1'b0, 1'b1};
    tbl[8] = '{0, 3'd2, 1'b0, 1'b0};
    tbl[9] = '{1, 3'd1, 1'b0, 1'b1};

    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_lvl", bus.LVL, 1);
    chk("rst_ram_w", bus.RAM_w, 0);
    chk("rst_wdata", bus.RAM_wdata, 0);
    chk("rst_valid", bus.digit_valid, 0);
    chk("rst_digit", bus.digit_out, 0);
    chk("rst_done", bus.display_done, 0);
    chk("rst_win", bus.win, 0);
    chk("rst_lose", bus.lose, 0);
    rst = 1'b1;
    step();
    chk("idle_lvl", bus.LVL, 1);
    chk("idle_valid", bus.digit_valid, 0);

    new_game();
    for (int i = 0; i < 10; i++) begin
      wait_act(tbl[i].act);
      if (tbl[i].win || tbl[i].lose) begin
        step();
        drive(1'b0, 1'b0, 1'b0);
        chk("outcome_win", bus.win, tbl[i].win);
        chk("outcome_lose", bus.lose, tbl[i].lose);
        chk("outcome_lvl", bus.LVL, tbl[i].lvl);
        terminal_hold(tbl[i].win, tbl[i].lose, tbl[i].lvl);
        new_game();
      end else begin
        play(tbl[i].lvl, 1'b1);
      end
    end

    // Reset in the middle of a level-3 playback.
    wait_act(0);
    play(2, 1'b0);
    wait_act(0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.digit_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("reach_show", bus.digit_valid, 1);
    chk("lvl3_before_reset", bus.LVL, 3);
    rst = 1'b0;
    #1;
    chk("midrst_valid", bus.digit_valid, 0);
    chk("midrst_digit", bus.digit_out, 0);
    chk("midrst_lvl", bus.LVL, 1);
    chk("midrst_done", bus.display_done, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.display_done !== 1'b0 || bus.digit_valid !== 1'b0 || bus.RAM_w !== 1'b0 ||
          bus.LVL !== 3'd1) bad++;
    end
    chk("post_reset_idle", bad, 0);
    new_game();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
